// File: rtl/adc_cfg_pkg.sv
// rtl/adc_cfg_pkg.sv - state encoding and codec register table for adc_cfg_sequencer
package adc_cfg_pkg;

   localparam int TBL_DEPTH = 8;
   localparam int IDX_W     = 3;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      GAP,
      VERIFY_ISSUE,
      VERIFY_WAIT,
      OK,
      FAIL
   } state_e;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } entry_t;

   // Entry 0 sits in the least significant byte.
   localparam logic [8*TBL_DEPTH-1:0] TBL_REG  = {8'h00, 8'h02, 8'h01, 8'h02,
                                                  8'h04, 8'h03, 8'h1A, 8'h1D};
   localparam logic [8*TBL_DEPTH-1:0] TBL_DATA = {8'h10, 8'h03, 8'h00, 8'h01,
                                                  8'h82, 8'h00, 8'h11, 8'h00};

endpackage

// File: rtl/adc_cfg_rom.sv
// rtl/adc_cfg_rom.sv - combinational index to {reg,data} lookup of the codec table
module adc_cfg_rom
   import adc_cfg_pkg::*;
(
   input  logic [IDX_W-1:0] idx_i,
   output entry_t           entry_o
);

   logic [5:0] bit_base;

   assign bit_base      = {idx_i, 3'b000};
   assign entry_o.addr  = TBL_REG[bit_base +: 8];
   assign entry_o.data  = TBL_DATA[bit_base +: 8];

endmodule

// File: rtl/adc_cfg_sequencer.sv
// rtl/adc_cfg_sequencer.sv - writes the codec table through a byte-level I2C master with NACK retry
// ADC_CFG_READBACK_EN adds a read-back check of every acknowledged write.
module adc_cfg_sequencer
   import adc_cfg_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR   = 7'h40,
   parameter int         MAX_RETRY  = 3,
   parameter int         GAP_CYCLES = 500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       m_req,
   output logic       m_rw,
   output logic [6:0] m_dev,
   output logic [7:0] m_reg,
   output logic [7:0] m_wdata,
   input  logic       m_ack,
   input  logic       m_done,
   input  logic       m_nack,
   input  logic [7:0] m_rdata,
   output logic       busy,
   output logic       cfg_ok,
   output logic       cfg_err,
   output logic [2:0] err_idx
);

   localparam int                 CNT_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [3:0]         RETRY_MAX = 4'(MAX_RETRY);
   localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(TBL_DEPTH - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d, idx_next, rom_idx;
   logic [3:0]       retry_q, retry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             adv_q, adv_d;
   logic [7:0]       reg_q, reg_d, wdata_q, wdata_d;
   logic             ok_q, ok_d, err_q, err_d;
   logic [2:0]       err_idx_q, err_idx_d;
   logic             load, retry_evt;
   entry_t           rom_entry;

   assign idx_next = (idx_q == IDX_LAST) ? idx_q : idx_q + 1'b1;
   // The ROM is addressed by the entry about to be issued so it can be latched on entry to ISSUE.
   assign rom_idx  = (state_q == IDLE) ? '0 : (adv_q ? idx_next : idx_q);

   adc_cfg_rom u_rom (
      .idx_i   (rom_idx),
      .entry_o (rom_entry)
   );

`ifdef ADC_CFG_READBACK_EN
   logic rw_q, rw_d;
   assign m_rw = rw_q;
`else
   logic unused_rdata;
   assign unused_rdata = ^m_rdata;
   assign m_rw         = 1'b0;
`endif

   assign m_req   = (state_q == ISSUE) || (state_q == VERIFY_ISSUE);
   assign m_dev   = DEV_ADDR;
   assign m_reg   = reg_q;
   assign m_wdata = wdata_q;
   assign busy    = (state_q != IDLE) && (state_q != OK) && (state_q != FAIL);
   assign cfg_ok  = ok_q;
   assign cfg_err = err_q;
   assign err_idx = err_idx_q;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      retry_d   = retry_q;
      cnt_d     = cnt_q;
      adv_d     = adv_q;
      reg_d     = reg_q;
      wdata_d   = wdata_q;
      ok_d      = ok_q;
      err_d     = err_q;
      err_idx_d = err_idx_q;
      load      = 1'b0;
      retry_evt = 1'b0;
`ifdef ADC_CFG_READBACK_EN
      rw_d      = rw_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ISSUE;
               idx_d   = '0;
               retry_d = '0;
               adv_d   = 1'b0;
               ok_d    = 1'b0;
               err_d   = 1'b0;
               load    = 1'b1;
            end
         end
         ISSUE: begin
            if (m_ack) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (m_done) begin
               if (!m_nack) begin
`ifdef ADC_CFG_READBACK_EN
                  state_d = VERIFY_ISSUE;
                  rw_d    = 1'b1;
`else
                  state_d = GAP;
                  cnt_d   = '0;
                  adv_d   = 1'b1;
`endif
               end else begin
                  retry_evt = 1'b1;
               end
            end
         end
`ifdef ADC_CFG_READBACK_EN
         VERIFY_ISSUE: begin
            if (m_ack) state_d = VERIFY_WAIT;
         end
         VERIFY_WAIT: begin
            if (m_done) begin
               if (!m_nack && (m_rdata == wdata_q)) begin
                  state_d = GAP;
                  cnt_d   = '0;
                  adv_d   = 1'b1;
               end else begin
                  retry_evt = 1'b1;
               end
            end
         end
`endif
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               if (adv_q && (idx_q == IDX_LAST)) begin
                  state_d = OK;
                  ok_d    = 1'b1;
               end else begin
                  state_d = ISSUE;
                  load    = 1'b1;
                  if (adv_q) begin
                     idx_d   = idx_next;
                     retry_d = '0;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         OK:      state_d = IDLE;
         FAIL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A NACK, or a failed read-back, reissues the write of the same entry after a gap.
      if (retry_evt) begin
         if (retry_q == RETRY_MAX) begin
            state_d   = FAIL;
            err_d     = 1'b1;
            err_idx_d = idx_q;
         end else begin
            state_d = GAP;
            cnt_d   = '0;
            adv_d   = 1'b0;
            retry_d = retry_q + 4'd1;
         end
      end

      if (load) begin
         reg_d   = rom_entry.addr;
         wdata_d = rom_entry.data;
`ifdef ADC_CFG_READBACK_EN
         rw_d    = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         retry_q   <= '0;
         cnt_q     <= '0;
         adv_q     <= 1'b0;
         reg_q     <= '0;
         wdata_q   <= '0;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
         err_idx_q <= '0;
`ifdef ADC_CFG_READBACK_EN
         rw_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         retry_q   <= retry_d;
         cnt_q     <= cnt_d;
         adv_q     <= adv_d;
         reg_q     <= reg_d;
         wdata_q   <= wdata_d;
         ok_q      <= ok_d;
         err_q     <= err_d;
         err_idx_q <= err_idx_d;
`ifdef ADC_CFG_READBACK_EN
         rw_q      <= rw_d;
`endif
      end
   end

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// tb/tb_adc_cfg_sequencer.sv - scoreboard bench for adc_cfg_sequencer with an I2C master model
`timescale 1ns/1ps
module tb_adc_cfg_sequencer;

   localparam int GAP   = 500;
   localparam int MAXR  = 3;
   localparam int LIMIT = 20000;
`ifdef ADC_CFG_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       start;
   logic       m_req;
   logic       m_rw;
   logic [6:0] m_dev;
   logic [7:0] m_reg;
   logic [7:0] m_wdata;
   logic       m_ack;
   logic       m_done;
   logic       m_nack;
   logic [7:0] m_rdata;
   logic       busy;
   logic       cfg_ok;
   logic       cfg_err;
   logic [2:0] err_idx;

   adc_cfg_sequencer #(
      .DEV_ADDR   (7'h40),
      .MAX_RETRY  (MAXR),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .m_req   (m_req),
      .m_rw    (m_rw),
      .m_dev   (m_dev),
      .m_reg   (m_reg),
      .m_wdata (m_wdata),
      .m_ack   (m_ack),
      .m_done  (m_done),
      .m_nack  (m_nack),
      .m_rdata (m_rdata),
      .busy    (busy),
      .cfg_ok  (cfg_ok),
      .cfg_err (cfg_err),
      .err_idx (err_idx)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      logic       rw;
      logic [7:0] addr;
      logic [7:0] data;
   } txn_t;

   txn_t       exp_q[$];
   logic [7:0] t_reg [8] = '{8'h1D, 8'h1A, 8'h03, 8'h04, 8'h02, 8'h01, 8'h02, 8'h00};
   logic [7:0] t_dat [8] = '{8'h00, 8'h11, 8'h00, 8'h82, 8'h01, 8'h00, 8'h03, 8'h10};
   int         nack_cnt [8];
   int         bad_rd [8];
   logic [7:0] slave_regs [256];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int txn_cnt  = 0;
   int done_lat = 3;
   int last_done = 0;
   int last_wr  = 0;
   bit gap_valid = 1'b0;
   bit master_idle = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int find_entry(input logic [7:0] a, input logic [7:0] d);
      for (int i = 0; i < 8; i++)
         if (t_reg[i] == a && t_dat[i] == d) return i;
      return -1;
   endfunction

   task automatic push_txn(input logic rw, input int i);
      txn_t t;
      t.rw   = rw;
      t.addr = t_reg[i];
      t.data = t_dat[i];
      exp_q.push_back(t);
   endtask

   task automatic push_ok(input int i);
      push_txn(1'b0, i);
      if (RB) push_txn(1'b1, i);
   endtask

   // Byte-level master: ack each request, complete it after done_lat cycles.
   initial begin : master
      m_ack   = 1'b0;
      m_done  = 1'b0;
      m_nack  = 1'b0;
      m_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (reset && m_req) begin : handle
            txn_t       e;
            logic       rw;
            logic [7:0] a;
            logic [7:0] d;
            int         ei;
            bit         nk;
            master_idle = 1'b0;
            rw = m_rw;
            a  = m_reg;
            d  = m_wdata;
            txn_cnt++;
            check_val("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_val("txn_rw", rw, e.rw);
               check_val("txn_reg", a, e.addr);
               if (!rw) check_val("txn_wdata", d, e.data);
            end
            check_val("m_dev", m_dev, 7'h40);
            if (!rw && gap_valid) check_val("gap_len_ok", (cyc - last_done) >= GAP, 1);
            m_ack = 1'b1;
            @(negedge clk);
            m_ack = 1'b0;
            check_val("req_drop_after_ack", m_req, 0);
            repeat (done_lat) @(negedge clk);
            nk = 1'b0;
            m_rdata = 8'h00;
            if (!rw) begin
               ei = find_entry(a, d);
               if (ei >= 0) begin
                  last_wr = ei;
                  if (nack_cnt[ei] < 0) nk = 1'b1;
                  else if (nack_cnt[ei] > 0) begin
                     nk = 1'b1;
                     nack_cnt[ei]--;
                  end
               end
               if (!nk) slave_regs[a] = d;
            end else begin
               m_rdata = slave_regs[a];
               if (bad_rd[last_wr] > 0) begin
                  bad_rd[last_wr]--;
                  m_rdata = 8'h80;
               end
            end
            m_done = 1'b1;
            m_nack = nk;
            @(negedge clk);
            m_done    = 1'b0;
            m_nack    = 1'b0;
            last_done = cyc;
            gap_valid = 1'b1;
            master_idle = 1'b1;
         end
      end
   end

   task automatic pulse_start(input bit chk);
      @(negedge clk);
      start = 1'b1;
      if (chk) gap_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      if (chk) begin
         check_val("first_issue_req", m_req, 1);
         check_val("busy_after_start", busy, 1);
         check_val("ok_cleared_on_start", cfg_ok, 0);
         check_val("err_cleared_on_start", cfg_err, 0);
      end
   endtask

   task automatic wait_end();
      int n = 0;
      while (!((cfg_ok || cfg_err) && !busy) && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check_val("end_in_time", n < LIMIT, 1);
   endtask

   task automatic wait_txn(input int target);
      int n = 0;
      while (txn_cnt < target && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check_val("txn_in_time", n < LIMIT, 1);
   endtask

   task automatic wait_master_idle();
      int n = 0;
      while (!master_idle && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      check_val("master_idle_in_time", n < LIMIT, 1);
   endtask

   task automatic expect_ok(input string tag);
      check_val({tag, "_cfg_ok"}, cfg_ok, 1);
      check_val({tag, "_cfg_err"}, cfg_err, 0);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_sb_drained"}, exp_q.size(), 0);
   endtask

   initial begin : watchdog
      #4000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int base;
      reset = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 256; i++) slave_regs[i] = 8'h00;
      for (int i = 0; i < 8; i++) begin
         nack_cnt[i] = 0;
         bad_rd[i]   = 0;
      end
      repeat (3) @(negedge clk);
      check_val("rst_m_req", m_req, 0);
      check_val("rst_m_rw", m_rw, 0);
      check_val("rst_m_reg", m_reg, 0);
      check_val("rst_m_wdata", m_wdata, 0);
      check_val("rst_m_dev", m_dev, 7'h40);
      check_val("rst_busy", busy, 0);
      check_val("rst_cfg_ok", cfg_ok, 0);
      check_val("rst_cfg_err", cfg_err, 0);
      check_val("rst_err_idx", err_idx, 0);
      @(negedge clk);
      reset = 1'b1;

      // Clean run, with a start pulse in the middle that must be ignored.
      for (int i = 0; i < 8; i++) push_ok(i);
      pulse_start(1'b1);
      wait_txn(txn_cnt + 3);
      pulse_start(1'b0);
      wait_end();
      expect_ok("clean");

      // Entry 2 NACKed twice, then accepted.
      nack_cnt[2] = 2;
      for (int i = 0; i < 2; i++) push_ok(i);
      push_txn(1'b0, 2);
      push_txn(1'b0, 2);
      for (int i = 2; i < 8; i++) push_ok(i);
      pulse_start(1'b1);
      wait_end();
      expect_ok("nack2");

      // Entries 0 and 1 each use all retries; the count must restart per entry.
      nack_cnt[0] = MAXR;
      nack_cnt[1] = MAXR;
      for (int r = 0; r < MAXR; r++) push_txn(1'b0, 0);
      push_ok(0);
      for (int r = 0; r < MAXR; r++) push_txn(1'b0, 1);
      for (int i = 1; i < 8; i++) push_ok(i);
      pulse_start(1'b1);
      wait_end();
      expect_ok("retry_clear");

      // Entry 4 never acknowledged: abort after MAX_RETRY+1 attempts.
      nack_cnt[4] = -1;
      for (int i = 0; i < 4; i++) push_ok(i);
      for (int r = 0; r <= MAXR; r++) push_txn(1'b0, 4);
      pulse_start(1'b1);
      wait_end();
      wait_master_idle();
      base = txn_cnt;
      repeat (GAP + 50) @(negedge clk);
      check_val("abort_cfg_err", cfg_err, 1);
      check_val("abort_cfg_ok", cfg_ok, 0);
      check_val("abort_err_idx", err_idx, 4);
      check_val("abort_busy", busy, 0);
      check_val("abort_no_entry5", txn_cnt, base);
      check_val("abort_sb_drained", exp_q.size(), 0);
      nack_cnt[4] = 0;

      // Reset while waiting for completion of entry 3, then a fresh start.
      for (int i = 0; i < 8; i++) push_ok(i);
      done_lat = 30;
      pulse_start(1'b1);
      wait_txn(txn_cnt + (RB ? 7 : 4));
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      check_val("midrst_m_req", m_req, 0);
      check_val("midrst_busy", busy, 0);
      check_val("midrst_m_reg", m_reg, 0);
      check_val("midrst_m_wdata", m_wdata, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      wait_master_idle();
      repeat (5) @(negedge clk);
      check_val("stray_done_busy", busy, 0);
      check_val("stray_done_cfg_ok", cfg_ok, 0);
      check_val("stray_done_cfg_err", cfg_err, 0);
      exp_q.delete();
      done_lat = 3;
      for (int i = 0; i < 8; i++) push_ok(i);
      pulse_start(1'b1);
      wait_end();
      expect_ok("after_reset");

`ifdef ADC_CFG_READBACK_EN
      // Read-back of reg 04 returns 80 once: the write is reissued.
      bad_rd[3] = 1;
      for (int i = 0; i < 3; i++) push_ok(i);
      push_txn(1'b0, 3);
      push_txn(1'b1, 3);
      for (int i = 3; i < 8; i++) push_ok(i);
      pulse_start(1'b1);
      wait_end();
      expect_ok("readback");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
